// File: rtl/nd8.sv
// rtl/nd8.sv - 8-input NAND with a registered copy of the result
//
// Purpose:
//   Y is the combinational NAND of A..H. YQ is Y captured on each rising CLK edge.
//   Y uses the 4-state reduction operator, so the following rules apply:
//     - Any input at 0 forces Y to 1, even when other inputs are X or Z.
//     - When no input is 0 and at least one input is X or Z, Y is X.
//   YQ stores whatever Y is, including X. YQ is not initialised before the first edge.
//
// Ports:
//   CLK  in   clock, rising-edge active
//   RST  in   synchronous active-high reset; forces YQ to 1 and never affects Y
//   A..H in   data inputs 0..7
//   Y    out  combinational NAND of A..H
//   YQ   out  Y registered with one cycle of latency

module nd8 (
    input  logic CLK,
    input  logic RST,
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    input  logic E,
    input  logic F,
    input  logic G,
    input  logic H,
    output logic Y,
    output logic YQ
);

    logic yq_q;
    logic yq_d;

    always_comb begin
        Y = ~&{A, B, C, D, E, F, G, H};
    end

    always_comb begin
        yq_d = Y;
    end

    // Reset takes priority over loading Y. It uses the NAND's idle-high value.
    always_ff @(posedge CLK) begin
        if (RST) begin
            yq_q <= 1'b1;
        end else begin
            yq_q <= yq_d;
        end
    end

    assign YQ = yq_q;

endmodule

// File: tb/tb_nd8.sv
// tb/tb_nd8.sv - directed self-checking bench for nd8

module tb_nd8;

    logic       clk;
    logic       rst;
    logic [7:0] vec;
    logic       y;
    logic       yq;
    logic       probe;
    bit         four_state;
    int         checks;
    int         failures;

    nd8 dut (
        .CLK (clk),
        .RST (rst),
        .A   (vec[0]),
        .B   (vec[1]),
        .C   (vec[2]),
        .D   (vec[3]),
        .E   (vec[4]),
        .F   (vec[5]),
        .G   (vec[6]),
        .H   (vec[7]),
        .Y   (y),
        .YQ  (yq)
    );

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    task automatic check(input string tag, input logic observed, input logic expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s vec(H..A)=%b got=%b exp=%b TEST FAILED", tag, vec, observed, expected);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        probe    = 1'bx;
        four_state = (probe !== 1'b0) && (probe !== 1'b1);

        // Reset with all inputs at 1: YQ=1 while Y=0.
        rst = 1'b1;
        vec = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        check("reset_yq", yq, 1'b1);
        check("reset_y", y, 1'b0);

        // All inputs at 1.
        rst = 1'b0;
        vec = 8'hFF;
        #10;
        check("all_ones_y", y, 1'b0);
        @(negedge clk);
        check("all_ones_yq", yq, 1'b0);

        // Walking zero: Y=1 immediately, YQ=1 after the next edge.
        for (int i = 0; i < 8; i++) begin
            vec = 8'hFF;
            vec[i] = 1'b0;
            #10;
            check($sformatf("walk0_y_%0d", i), y, 1'b1);
            @(negedge clk);
            check($sformatf("walk0_yq_%0d", i), yq, 1'b1);
        end

        // X handling. A 2-state simulator resolves X to 0 or 1, so the
        // expected value is then the NAND of whatever A actually holds.
        vec = 8'hFF;
        vec[0] = 1'bx;
        #10;
        if (four_state) check("x_only_y", y, 1'bx);
        else            check("x_only_y", y, ~&vec);
        vec[1] = 1'b0;
        #10;
        check("x_with_zero_y", y, 1'b1);
        @(negedge clk);

        // Reset during operation.
        vec = 8'hFF;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_yq", yq, 1'b1);
        check("midrst_y", y, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_yq", yq, 1'b0);

        // Latency: YQ follows Y one edge later and ignores glitches between edges.
        vec[7] = 1'b0;
        #10;
        check("lat_y_h0", y, 1'b1);
        check("lat_yq_hold0", yq, 1'b0);
        @(negedge clk);
        check("lat_yq_h0", yq, 1'b1);
        vec[7] = 1'b1;
        #5;
        vec[7] = 1'b0;
        #5;
        check("glitch_yq_hold", yq, 1'b1);
        @(negedge clk);
        check("glitch_yq_after", yq, 1'b1);
        vec[7] = 1'b1;
        #10;
        check("lat_y_h1", y, 1'b0);
        check("lat_yq_hold1", yq, 1'b1);
        @(negedge clk);
        check("lat_yq_h1", yq, 1'b0);

        if (failures == 0) $display("TEST PASSED");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
